// File: rtl/carga_pkg.sv
// Shared definitions for the serial-to-parallel front end of the comparison network:
// FSM encoding, default word width and the derived beat-counter width.
package carga_pkg;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        CARGA  = 2'd1,
        LLENO  = 2'd2
    } estado_t;

    localparam int N_PAL = 3;

    // Counter must be able to hold the value N itself
    function automatic int anchoCuenta(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/registro_serie_paralelo.sv
// N-bit LSB-first shift register: bits enter at the MSB and walk towards bit 0,
// so after N accepted beats the first beat sits in bit 0.
module registro_serie_paralelo
    import carga_pkg::*;
#(
    parameter int N = N_PAL
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cargaPrimero,
    input  logic         desplazar,
    input  logic         bitEnt,
    output logic [N-1:0] palabra
);

    logic [N-1:0] palabra_r;

    // Load-first clears the old partial word; the new bit starts at the MSB like any shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            palabra_r <= {N{1'b0}};
        end else if (cargaPrimero) begin
            palabra_r <= {bitEnt, {(N-1){1'b0}}};
        end else if (desplazar) begin
            palabra_r <= {bitEnt, palabra_r[N-1:1]};
        end else begin
            palabra_r <= palabra_r;
        end
    end

    assign palabra = palabra_r;

endmodule

// File: rtl/carga_serie_d_i.sv
// Serial front end: assembles LSB-first bit pairs into palabraA/palabraB, holds them
// behind valid/ready, and republishes the network result Z as a registered pulse.
module carga_serie_d_i
    import carga_pkg::*;
#(
    parameter int N = N_PAL
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_valid,
    input  logic         bit_first,
    input  logic         bit_a,
    input  logic         bit_b,
    output logic         bit_ready,
    output logic [N-1:0] palabraA,
    output logic [N-1:0] palabraB,
    output logic         pal_valid,
    input  logic         pal_ready,
    input  logic         Z,
    output logic         resultado,
    output logic         res_valid,
    output logic         desinc
);

    localparam int CW = anchoCuenta(N);

    estado_t         estado_r;
    estado_t         estadoSig_s;
    logic [CW-1:0]   cuenta_r;
    logic [CW-1:0]   cuentaSig_s;
    logic            acepta_s;
    logic            cargaPrimero_s;
    logic            desplazar_s;
    logic            entrega_s;
    logic            desincSig_s;
    logic            resultado_r;
    logic            resValid_r;
    logic            desinc_r;

    assign bit_ready = (estado_r != LLENO);
    assign pal_valid = (estado_r == LLENO);
    assign acepta_s  = bit_valid & bit_ready;

    // Next-state, counter and shift-control decode
    always_comb begin
        estadoSig_s    = estado_r;
        cuentaSig_s    = cuenta_r;
        cargaPrimero_s = 1'b0;
        desplazar_s    = 1'b0;
        entrega_s      = 1'b0;
        desincSig_s    = 1'b0;
        case (estado_r)
            ESPERA: begin
                if (acepta_s && bit_first) begin
                    cargaPrimero_s = 1'b1;
                    cuentaSig_s    = CW'(1);
                    estadoSig_s    = CARGA;
                end else begin
                    estadoSig_s = ESPERA;
                end
            end
            CARGA: begin
                if (acepta_s && bit_first) begin
                    // A new bit 0 mid-word means the sender slipped; restart on this beat
                    cargaPrimero_s = 1'b1;
                    cuentaSig_s    = CW'(1);
                    desincSig_s    = 1'b1;
                end else if (acepta_s) begin
                    desplazar_s = 1'b1;
                    cuentaSig_s = cuenta_r + CW'(1);
                    if (cuenta_r == CW'(N - 1)) begin
                        estadoSig_s = LLENO;
                    end else begin
                        estadoSig_s = CARGA;
                    end
                end else begin
                    estadoSig_s = CARGA;
                end
            end
            LLENO: begin
                if (pal_ready) begin
                    entrega_s   = 1'b1;
                    cuentaSig_s = {CW{1'b0}};
                    estadoSig_s = ESPERA;
                end else begin
                    estadoSig_s = LLENO;
                end
            end
            default: begin
                cuentaSig_s = {CW{1'b0}};
                estadoSig_s = ESPERA;
            end
        endcase
    end

    // State, counter, sampled result and single-cycle pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r    <= ESPERA;
            cuenta_r    <= {CW{1'b0}};
            resultado_r <= 1'b0;
            resValid_r  <= 1'b0;
            desinc_r    <= 1'b0;
        end else begin
            estado_r    <= estadoSig_s;
            cuenta_r    <= cuentaSig_s;
            resultado_r <= entrega_s ? Z : resultado_r;
            resValid_r  <= entrega_s;
            desinc_r    <= desincSig_s;
        end
    end

    assign resultado = resultado_r;
    assign res_valid = resValid_r;
    assign desinc    = desinc_r;

    registro_serie_paralelo #(.N(N)) regA (
        .clk          (clk),
        .reset        (reset),
        .cargaPrimero (cargaPrimero_s),
        .desplazar    (desplazar_s),
        .bitEnt       (bit_a),
        .palabra      (palabraA)
    );

    registro_serie_paralelo #(.N(N)) regB (
        .clk          (clk),
        .reset        (reset),
        .cargaPrimero (cargaPrimero_s),
        .desplazar    (desplazar_s),
        .bitEnt       (bit_b),
        .palabra      (palabraB)
    );

endmodule

// File: tb/tb_carga_serie_d_i.sv
// Bench for carga_serie_d_i: a queue-based model of the serial protocol checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_carga_serie_d_i;

    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic         bit_valid;
    logic         bit_first;
    logic         bit_a;
    logic         bit_b;
    logic         bit_ready;
    logic [N-1:0] palabraA;
    logic [N-1:0] palabraB;
    logic         pal_valid;
    logic         pal_ready;
    logic         Z;
    logic         resultado;
    logic         res_valid;
    logic         desinc;

    int nChecks = 0;
    int nFails  = 0;
    int desincCnt = 0;

    carga_serie_d_i #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .bit_first (bit_first),
        .bit_a     (bit_a),
        .bit_b     (bit_b),
        .bit_ready (bit_ready),
        .palabraA  (palabraA),
        .palabraB  (palabraB),
        .pal_valid (pal_valid),
        .pal_ready (pal_ready),
        .Z         (Z),
        .resultado (resultado),
        .res_valid (res_valid),
        .desinc    (desinc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the accepted bits of the word in progress, oldest first
    int           qa[$];
    int           qb[$];
    bit           mHold = 1'b0;
    logic         mRes = 1'b0;
    logic         mResValid = 1'b0;
    logic         mDesinc = 1'b0;
    logic [N-1:0] mA = '0;
    logic [N-1:0] mB = '0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                qa.delete(); qb.delete();
                mHold = 1'b0; mRes = 1'b0; mResValid = 1'b0; mDesinc = 1'b0;
                mA = '0; mB = '0;
            end else begin
                mResValid = 1'b0;
                mDesinc   = 1'b0;
                if (mHold) begin
                    if (pal_ready) begin
                        mRes = Z; mResValid = 1'b1; mHold = 1'b0;
                        qa.delete(); qb.delete();
                    end
                end else if (bit_valid) begin
                    if (bit_first) begin
                        if (qa.size() > 0) mDesinc = 1'b1;
                        qa.delete(); qb.delete();
                        qa.push_back(int'(bit_a)); qb.push_back(int'(bit_b));
                    end else if (qa.size() > 0) begin
                        qa.push_back(int'(bit_a)); qb.push_back(int'(bit_b));
                    end
                    if (qa.size() == N) begin
                        mHold = 1'b1;
                        mA = '0; mB = '0;
                        for (int i = 0; i < N; i++) begin
                            mA = mA + N'(qa[i] << i);
                            mB = mB + N'(qb[i] << i);
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison, sampled mid low phase
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("m_bit_ready", bit_ready, !mHold);
            check("m_pal_valid", pal_valid, mHold);
            if (mHold) begin
                check("m_palabraA", palabraA, mA);
                check("m_palabraB", palabraB, mB);
            end
            check("m_resultado", resultado, mRes);
            check("m_res_valid", res_valid, mResValid);
            check("m_desinc", desinc, mDesinc);
            if (desinc === 1'b1) desincCnt++;
        end
    end

    task automatic beat(input logic a, input logic b, input logic f);
        @(negedge clk);
        bit_valid = 1'b1; bit_a = a; bit_b = b; bit_first = f;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid = 1'b0; bit_first = 1'b0;
        end
    endtask

    int d0;

    initial begin
        reset = 1'b1; bit_valid = 1'b0; bit_first = 1'b0;
        bit_a = 1'b0; bit_b = 1'b0; pal_ready = 1'b0; Z = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("rst_bit_ready", bit_ready, 1);
        check("rst_pal_valid", pal_valid, 0);
        check("rst_palabraA", palabraA, 0);
        check("rst_res_valid", res_valid, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic load, immediate hand-off
        pal_ready = 1'b1; Z = 1'b1;
        beat(1, 1, 1); beat(0, 1, 0); beat(1, 0, 0);
        #3 check("basic_not_yet_valid", pal_valid, 0);
        idle(1);
        #3;
        check("basic_pal_valid", pal_valid, 1);
        check("basic_palabraA", palabraA, 3'b101);
        check("basic_palabraB", palabraB, 3'b011);
        @(negedge clk); #3;
        check("basic_res_valid", res_valid, 1);
        check("basic_resultado", resultado, 1);
        check("basic_released", pal_valid, 0);
        @(negedge clk); #3;
        check("basic_res_pulse_end", res_valid, 0);

        // Backpressure with extra beats offered in LLENO
        pal_ready = 1'b0; Z = 1'b0;
        beat(1, 1, 1); beat(0, 1, 0); beat(1, 0, 0);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bit_valid = 1'b1; bit_first = 1'b1; bit_a = 1'b0; bit_b = 1'b0;
            #3;
            check("bp_pal_valid", pal_valid, 1);
            check("bp_bit_ready", bit_ready, 0);
            check("bp_palabraA", palabraA, 3'b101);
            check("bp_palabraB", palabraB, 3'b011);
        end
        @(negedge clk);
        bit_valid = 1'b0; bit_first = 1'b0; pal_ready = 1'b1;
        @(negedge clk); #3;
        check("bp_res_valid", res_valid, 1);
        check("bp_resultado", resultado, 0);

        // Leading garbage then 110/001
        Z = 1'b1;
        beat(1, 0, 0); beat(1, 1, 0);
        beat(0, 1, 1); beat(1, 0, 0); beat(1, 0, 0);
        idle(1); #3;
        check("garb_palabraA", palabraA, 3'b110);
        check("garb_palabraB", palabraB, 3'b001);
        idle(2);

        // Resync mid-word
        d0 = desincCnt;
        beat(1, 1, 1); beat(0, 0, 0);
        beat(0, 1, 1); beat(1, 1, 0); beat(1, 0, 0);
        idle(1); #3;
        check("resync_palabraA", palabraA, 3'b110);
        check("resync_palabraB", palabraB, 3'b011);
        idle(2);
        check("resync_desinc_count", desincCnt - d0, 1);

        // Gapped input
        pal_ready = 1'b0; Z = 1'b1;
        beat(1, 1, 1); idle(3); beat(0, 1, 0); idle(3); beat(1, 0, 0);
        #3 check("gap_not_yet_valid", pal_valid, 0);
        idle(1); #3;
        check("gap_pal_valid", pal_valid, 1);
        check("gap_palabraA", palabraA, 3'b101);
        check("gap_palabraB", palabraB, 3'b011);
        pal_ready = 1'b1;
        idle(2);
        check("gap_resultado", resultado, 1);

        // Reset mid-word
        pal_ready = 1'b0;
        beat(1, 1, 1); beat(0, 1, 0);
        @(negedge clk);
        bit_valid = 1'b0; bit_first = 1'b0; reset = 1'b1;
        #3;
        check("rmw_bit_ready", bit_ready, 1);
        check("rmw_pal_valid", pal_valid, 0);
        check("rmw_palabraA", palabraA, 0);
        check("rmw_palabraB", palabraB, 0);
        check("rmw_resultado", resultado, 0);
        @(negedge clk);
        reset = 1'b0;
        beat(0, 1, 1); beat(1, 0, 0); beat(1, 0, 0);
        idle(1); #3;
        check("rmw_next_palabraA", palabraA, 3'b110);
        check("rmw_next_palabraB", palabraB, 3'b001);

        // Reset in LLENO with beats offered during reset
        @(negedge clk);
        reset = 1'b1; bit_valid = 1'b1; bit_first = 1'b1; bit_a = 1'b1; bit_b = 1'b1;
        #3;
        check("rll_pal_valid", pal_valid, 0);
        check("rll_bit_ready", bit_ready, 1);
        check("rll_palabraA", palabraA, 0);
        @(negedge clk);
        reset = 1'b0; bit_valid = 1'b0; bit_first = 1'b0;
        pal_ready = 1'b1; Z = 1'b1;
        beat(1, 1, 1); beat(0, 1, 0); beat(1, 0, 0);
        idle(1); #3;
        check("rll_next_palabraA", palabraA, 3'b101);
        check("rll_next_palabraB", palabraB, 3'b011);
        @(negedge clk); #3;
        check("rll_next_res_valid", res_valid, 1);
        check("rll_next_resultado", resultado, 1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/carga_serie_d_i.md
# carga_serie_d_i

Serial-to-parallel front end for the right-to-left comparison network. It accepts word pairs one bit-pair per beat, least-significant bit first, matching the network's right-to-left cell order. It assembles them into `palabraA`/`palabraB` and holds them stable behind a valid/ready handshake while the combinational network evaluates. It samples the network's `Z` output back at hand-off and republishes it as a registered, single-pulse result.

## Interface
- `N`, default 3: word width; legal range N ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `bit_valid` in 1: serial beat present.
- `bit_first` in 1: beat carries bit 0 of a new word pair.
- `bit_a` in 1: serial bit of word A.
- `bit_b` in 1: serial bit of word B.
- `bit_ready` out 1: block accepts a beat this cycle.
- `palabraA` out N: assembled word A, meaningful only while `pal_valid`=1.
- `palabraB` out N: assembled word B, meaningful only while `pal_valid`=1.
- `pal_valid` out 1: words complete and stable.
- `pal_ready` in 1: downstream network consumer takes the words.
- `Z` in 1: network result for the presented words.
- `resultado` out 1: registered copy of `Z`.
- `res_valid` out 1: one-cycle pulse, `resultado` updated.
- `desinc` out 1: one-cycle pulse, word restarted by a mid-word `bit_first`.

## Operation
- A beat is accepted when `bit_valid` & `bit_ready` at a rising edge.
- FSM states:
  - ESPERA (idle): `bit_ready`=1. An accepted beat with `bit_first`=0 is dropped and causes no state change. An accepted beat with `bit_first`=1 loads bit 0, sets count=1, and goes to CARGA.
  - CARGA: `bit_ready`=1. Each accepted beat shifts in (`reg <= {bit, reg[N-1:1]}`) and increments count. When count reaches N the FSM goes to LLENO.
  - LLENO: `bit_ready`=0, `pal_valid`=1, words frozen. On `pal_valid` & `pal_ready` at an edge: `resultado` <= `Z`, `res_valid` pulses for the next cycle, FSM returns to ESPERA.
- Resync rule: an accepted beat in CARGA with `bit_first`=1 discards the partial word. That beat becomes bit 0, count=1, the FSM stays in CARGA, and `desinc` pulses for the next cycle.
- `bit_valid`=0 in CARGA holds all state; there is no timeout.
- `pal_ready` is ignored outside LLENO.
- `Z` is sampled only on the LLENO hand-off edge.
- Reset, including mid-word or in LLENO, forces:
  - state = ESPERA, count = 0
  - shift registers = 0, so `palabraA` = `palabraB` = 0
  - `pal_valid` = 0, `resultado` = 0, `res_valid` = 0, `desinc` = 0
- Beats presented while `reset`=1 are ignored.
- `bit_ready` is decoded from state and reads 1 out of reset.

## Timing
- Minimum load latency: first beat accepted at edge t0, N-th beat at t0+N-1. `pal_valid` is high from the cycle after edge t0+N-1.
- If `pal_ready` is already high, hand-off occurs at the next edge. `res_valid` is high in the following cycle only.
- Best-case throughput: one word pair per N+1 cycles. No beat is accepted in LLENO.
- `palabraA`/`palabraB` do not change while `pal_valid`=1.
- `Z` must settle from the network combinationally within the same cycle.
- All outputs are registered or pure state decodes. There is no combinational path from `bit_*` or `pal_ready` to any output.

## Structure
- Shared package `carga_pkg`:
  - state encoding ESPERA/CARGA/LLENO
  - default width constant `N_PAL` = 3
  - count width derived from N
- Sub-module `registro_serie_paralelo` (N-bit LSB-first shift register with load-first and shift-enable controls), instantiated twice: once for A, once for B.
- The FSM, counter, result register and pulse logic live in the top.

## Test plan
- Basic load, N=3, `pal_ready`=1: beats (a,b) = (1,1)f, (0,1), (1,0) with `bit_first` on beat 1 → `palabraA`=101, `palabraB`=011, `pal_valid` one cycle after third beat. With `Z`=1 → `resultado`=1, `res_valid` one-cycle pulse.
- Backpressure: same load, `pal_ready`=0 for 5 cycles → `pal_valid` held, words stable, `bit_ready`=0. Extra beats are not accepted.
- Leading garbage: two beats with `bit_first`=0 in ESPERA, then a valid word 110/001 → garbage dropped, words = 110/001.
- Resync: `bit_first` beat, one data beat, then `bit_first` beat with (0,1), (1,1), (1,0) → `desinc` pulses once, words = 110/011.
- Gapped input: `bit_valid` low 3 cycles between beats → same words as gap-free. `pal_valid` asserts after the last beat.
- Reset mid-word and in LLENO: `reset` pulse → all outputs 0, `bit_ready`=1. The next full word loads correctly.
